id2exe_skid_reg: RTL and testbench

//  Parametrised ID->EXE pipeline register with valid/ready handshake and a 2-entry skid buffer.

---
 rtl/id2exe_skid_reg_pkg.sv | 38 +++
 rtl/id2exe_skid_reg_if.sv | 21 ++
 rtl/id2exe_skid_reg_entry.sv | 36 +++
 rtl/id2exe_skid_reg.sv | 94 +++++++++
 tb/tb_id2exe_skid_reg.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/id2exe_skid_reg_pkg.sv
// Shared decode/execute definitions: control-bundle layout, EXE command codes, default widths.
package id2exe_skid_reg_pkg;

  localparam int unsigned DEF_CTRL_W  = 9;
  localparam int unsigned DEF_DATA_W  = 32;
  localparam int unsigned DEF_NUM_OPS = 2;
  localparam int unsigned DEF_IMM_W   = 24;
  localparam int unsigned DEF_REG_W   = 4;
  localparam int unsigned DEF_CNT_W   = 16;

  // Bit offsets inside the control bundle; EXE_CMD occupies [3:0]
  localparam int unsigned CTRL_EXE_CMD = 0;
  localparam int unsigned CTRL_S       = 4;
  localparam int unsigned CTRL_B       = 5;
  localparam int unsigned CTRL_MEM_W   = 6;
  localparam int unsigned CTRL_MEM_R   = 7;
  localparam int unsigned CTRL_WB_EN   = 8;

  typedef enum logic [3:0] {
    EXE_NOP = 4'd0,
    EXE_MOV = 4'd1,
    EXE_ADD = 4'd2,
    EXE_ADC = 4'd3,
    EXE_SUB = 4'd4,
    EXE_SBC = 4'd5,
    EXE_AND = 4'd6,
    EXE_ORR = 4'd7,
    EXE_EOR = 4'd8,
    EXE_MVN = 4'd9
  } exe_cmd_e;

  // Width of the non-control payload {pc, ops, imm, regs}
  function automatic int unsigned payload_w(input int unsigned data_w, input int unsigned num_ops,
                                            input int unsigned imm_w, input int unsigned reg_w);
    return data_w * (num_ops + 1) + imm_w + 3 * reg_w;
  endfunction

endpackage

// File: rtl/id2exe_skid_reg_if.sv
// Valid/ready instruction bus between pipeline stages.
interface id2exe_skid_reg_if
  import id2exe_skid_reg_pkg::*;
#(
  parameter int unsigned CTRL_W  = DEF_CTRL_W,
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter int unsigned NUM_OPS = DEF_NUM_OPS,
  parameter int unsigned IMM_W   = DEF_IMM_W,
  parameter int unsigned REG_W   = DEF_REG_W
);
  logic                        valid;
  logic                        ready;
  logic [CTRL_W-1:0]           ctrl;
  logic [DATA_W-1:0]           pc;
  logic [NUM_OPS*DATA_W-1:0]   ops;
  logic [IMM_W-1:0]            imm;
  logic [3*REG_W-1:0]          regs;

  modport master (output valid, ctrl, pc, ops, imm, regs, input ready);
  modport slave  (input valid, ctrl, pc, ops, imm, regs, output ready);
endinterface

// File: rtl/id2exe_skid_reg_entry.sv
// One pipeline entry: valid bit, control (zero whenever invalid) and payload.
module pipe_entry_reg #(
  parameter int unsigned CTRL_W     = 9,
  parameter int unsigned PAY_W      = 32,
  parameter bit          CLEAR_DATA = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              drop,
  input  logic              flush,
  input  logic [CTRL_W-1:0] d_ctrl,
  input  logic [PAY_W-1:0]  d_pay,
  output logic              valid,
  output logic [CTRL_W-1:0] q_ctrl,
  output logic [PAY_W-1:0]  q_pay
);

  // Payload is only zeroed by flush (when enabled); a normal drain leaves it stale
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid  <= 1'b0;
      q_ctrl <= '0;
      q_pay  <= '0;
    end else if (flush || drop) begin
      valid  <= 1'b0;
      q_ctrl <= '0;
      if (flush && CLEAR_DATA) q_pay <= '0;
    end else if (load) begin
      valid  <= 1'b1;
      q_ctrl <= d_ctrl;
      q_pay  <= d_pay;
    end
  end

endmodule

// File: rtl/id2exe_skid_reg.sv
// ID->EXE pipeline register with registered ready, 2-entry skid storage, flush and stall counter.
module id2exe_skid_reg
  import id2exe_skid_reg_pkg::*;
#(
  parameter int unsigned CTRL_W     = DEF_CTRL_W,
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter int unsigned NUM_OPS    = DEF_NUM_OPS,
  parameter int unsigned IMM_W      = DEF_IMM_W,
  parameter int unsigned REG_W      = DEF_REG_W,
  parameter int unsigned CNT_W      = DEF_CNT_W,
  parameter bit          CLEAR_DATA = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  id2exe_skid_reg_if.slave   in_if,
  id2exe_skid_reg_if.master  out_if,
  output logic [CNT_W-1:0]   stall_cnt
);

  localparam int unsigned PAY_W = payload_w(DATA_W, NUM_OPS, IMM_W, REG_W);

  logic              ready_q, push, pop;
  logic              m_v, s_v, s_v_next;
  logic              m_load, m_from_s, m_drop, s_load, s_drop;
  logic [CTRL_W-1:0] m_ctrl, s_ctrl, m_d_ctrl;
  logic [PAY_W-1:0]  m_pay, s_pay, m_d_pay, in_pay;

  assign in_pay = {in_if.pc, in_if.ops, in_if.imm, in_if.regs};
  assign push   = in_if.valid & ready_q;
  assign pop    = m_v & out_if.ready;

  // Entry control: S always drains into M before fresh input is taken
  always_comb begin
    m_load   = 1'b0;
    m_from_s = 1'b0;
    m_drop   = 1'b0;
    s_load   = 1'b0;
    s_drop   = 1'b0;
    s_v_next = s_v;
    if (flush) begin
      s_v_next = 1'b0;
    end else if (!m_v) begin
      m_load = push;
    end else if (pop) begin
      if (s_v) begin
        m_load   = 1'b1;
        m_from_s = 1'b1;
        s_drop   = 1'b1;
        s_v_next = 1'b0;
      end else if (push) begin
        m_load = 1'b1;
      end else begin
        m_drop = 1'b1;
      end
    end else if (push) begin
      s_load   = 1'b1;
      s_v_next = 1'b1;
    end
  end

  assign m_d_ctrl = m_from_s ? s_ctrl : in_if.ctrl;
  assign m_d_pay  = m_from_s ? s_pay  : in_pay;

  pipe_entry_reg #(.CTRL_W(CTRL_W), .PAY_W(PAY_W), .CLEAR_DATA(CLEAR_DATA)) u_main (
    .clk(clk), .rst(rst), .load(m_load), .drop(m_drop), .flush(flush),
    .d_ctrl(m_d_ctrl), .d_pay(m_d_pay), .valid(m_v), .q_ctrl(m_ctrl), .q_pay(m_pay)
  );

  pipe_entry_reg #(.CTRL_W(CTRL_W), .PAY_W(PAY_W), .CLEAR_DATA(CLEAR_DATA)) u_skid (
    .clk(clk), .rst(rst), .load(s_load), .drop(s_drop), .flush(flush),
    .d_ctrl(in_if.ctrl), .d_pay(in_pay), .valid(s_v), .q_ctrl(s_ctrl), .q_pay(s_pay)
  );

  // Ready looks one cycle ahead at skid occupancy so no combinational path from out ready
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ready_q <= 1'b1;
    else      ready_q <= !s_v_next;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
    end else if (m_v && !out_if.ready && !flush && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  assign in_if.ready  = ready_q;
  assign out_if.valid = m_v;
  assign out_if.ctrl  = m_ctrl;
  assign {out_if.pc, out_if.ops, out_if.imm, out_if.regs} = m_pay;

endmodule

// File: tb/tb_id2exe_skid_reg.sv
// Bench for id2exe_skid_reg: queue model compared every cycle plus directed literal checks.
module tb_id2exe_skid_reg;
  import id2exe_skid_reg_pkg::*;

  typedef struct packed {
    logic [8:0]  ctrl;
    logic [31:0] pc;
    logic [63:0] ops;
    logic [23:0] imm;
    logic [11:0] regs;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        flush6 = 1'b0;
  logic [15:0] stall_cnt, stall6;
  int          checks = 0;
  int          errors = 0;
  bit          cmp_en = 1'b0;

  ent_t        q[$];
  bit          m_ready = 1'b1;
  logic [15:0] m_cnt = 16'd0;
  bit          push_m, pop_m;

  id2exe_skid_reg_if i_if ();
  id2exe_skid_reg_if o_if ();
  id2exe_skid_reg_if #(.DATA_W(16), .NUM_OPS(3)) i6 ();
  id2exe_skid_reg_if #(.DATA_W(16), .NUM_OPS(3)) o6 ();

  id2exe_skid_reg #(.CNT_W(16), .CLEAR_DATA(1'b1)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_if(i_if), .out_if(o_if), .stall_cnt(stall_cnt)
  );

  id2exe_skid_reg #(.DATA_W(16), .NUM_OPS(3), .CNT_W(16), .CLEAR_DATA(1'b0)) dut6 (
    .clk(clk), .rst(rst), .flush(flush6), .in_if(i6), .out_if(o6), .stall_cnt(stall6)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string name, input logic [159:0] got, input logic [159:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got %0h expected %0h", name, $time, got, exp);
    end
  endtask

  function automatic ent_t mk(input int id);
    ent_t e;
    e.ctrl = '0;
    e.ctrl[CTRL_WB_EN] = 1'b1;
    e.ctrl[CTRL_EXE_CMD +: 4] = 4'(id);
    e.pc   = 32'h1000 + 32'(id) * 32'd4;
    e.ops  = {32'(id * 3), 32'hA500_0000 | 32'(id)};
    e.imm  = 24'(-id);
    e.regs = 12'(id * 7);
    return e;
  endfunction

  task automatic step(input bit v, input int id, input bit ordy, input bit fl);
    i_if.valid = v;
    {i_if.ctrl, i_if.pc, i_if.ops, i_if.imm, i_if.regs} = mk(id);
    o_if.ready = ordy;
    flush = fl;
    @(posedge clk);
    #1;
  endtask

  // Model: FIFO of capacity 2; ready means fewer than two entries held
  initial forever begin
    @(posedge clk or negedge rst);
    if (!rst) begin
      q.delete();
      m_ready = 1'b1;
      m_cnt = 16'd0;
    end else begin
      push_m = i_if.valid && m_ready;
      pop_m  = (q.size() != 0) && o_if.ready;
      if ((q.size() != 0) && !o_if.ready && !flush && (m_cnt != 16'hFFFF)) m_cnt = m_cnt + 16'd1;
      if (flush) begin
        q.delete();
      end else begin
        if (pop_m) void'(q.pop_front());
        if (push_m) q.push_back({i_if.ctrl, i_if.pc, i_if.ops, i_if.imm, i_if.regs});
      end
      m_ready = (q.size() < 2);
    end
  end

  // Per-cycle comparison against the model
  initial forever begin
    @(negedge clk);
    if (cmp_en) begin
      chk("out_valid", 160'(o_if.valid), 160'(q.size() != 0));
      chk("in_ready", 160'(i_if.ready), 160'(m_ready));
      chk("out_ctrl", 160'(o_if.ctrl), (q.size() != 0) ? 160'(q[0].ctrl) : 160'(0));
      chk("stall_cnt", 160'(stall_cnt), 160'(m_cnt));
      if (q.size() != 0)
        chk("payload", 160'({o_if.pc, o_if.ops, o_if.imm, o_if.regs}),
            160'({q[0].pc, q[0].ops, q[0].imm, q[0].regs}));
    end
  end

  initial begin
    logic [47:0] ops6;
    i_if.valid = 1'b0;
    {i_if.ctrl, i_if.pc, i_if.ops, i_if.imm, i_if.regs} = '0;
    o_if.ready = 1'b0;
    i6.valid = 1'b0;
    {i6.ctrl, i6.pc, i6.ops, i6.imm, i6.regs} = '0;
    o6.ready = 1'b0;

    #6;
    chk("rst_out_valid", 160'(o_if.valid), 160'(0));
    chk("rst_in_ready", 160'(i_if.ready), 160'(1));
    chk("rst_out_ctrl", 160'(o_if.ctrl), 160'(0));
    chk("rst_stall_cnt", 160'(stall_cnt), 160'(0));
    chk("rst_out_pc", 160'(o_if.pc), 160'(0));
    #6 rst = 1'b1;
    @(posedge clk);
    #1;
    cmp_en = 1'b1;

    // Streaming at full rate
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, i, 1'b1, 1'b0);
      if (i == 1) chk("stream_first_pc", 160'(o_if.pc), 160'(32'h1004));
    end
    step(1'b0, 0, 1'b1, 1'b0);
    step(1'b0, 0, 1'b1, 1'b0);
    chk("stream_stall_cnt", 160'(stall_cnt), 160'(0));

    // Backpressure fills main and skid
    step(1'b1, 10, 1'b0, 1'b0);
    chk("bp_ready_after_a", 160'(i_if.ready), 160'(1));
    step(1'b1, 11, 1'b0, 1'b0);
    chk("bp_ready_full", 160'(i_if.ready), 160'(0));
    chk("bp_head_a", 160'(o_if.pc), 160'(32'h1028));
    step(1'b0, 0, 1'b0, 1'b0);
    step(1'b0, 0, 1'b0, 1'b0);
    chk("bp_stall_cnt", 160'(stall_cnt), 160'(3));
    step(1'b0, 0, 1'b1, 1'b0);
    chk("bp_head_b", 160'(o_if.pc), 160'(32'h102C));
    step(1'b0, 0, 1'b1, 1'b0);

    // Flush with both entries full and a new instruction offered
    step(1'b1, 20, 1'b0, 1'b0);
    step(1'b1, 21, 1'b0, 1'b0);
    step(1'b1, 22, 1'b0, 1'b1);
    chk("flush_valid", 160'(o_if.valid), 160'(0));
    chk("flush_ctrl", 160'(o_if.ctrl), 160'(0));
    chk("flush_ready", 160'(i_if.ready), 160'(1));
    chk("flush_pc_cleared", 160'(o_if.pc), 160'(0));
    chk("flush_stall_cnt", 160'(stall_cnt), 160'(4));
    step(1'b1, 23, 1'b1, 1'b0);
    chk("flush_next_pc", 160'(o_if.pc), 160'(32'h105C));
    step(1'b0, 0, 1'b1, 1'b0);

    // Long stall saturates the counter
    step(1'b1, 30, 1'b0, 1'b0);
    for (int k = 0; k < 65540; k++) step(1'b0, 0, 1'b0, 1'b0);
    chk("sat_stall_cnt", 160'(stall_cnt), 160'(16'hFFFF));

    // Asynchronous reset while skid entry is occupied
    step(1'b1, 40, 1'b0, 1'b0);
    chk("pre_rst_ready", 160'(i_if.ready), 160'(0));
    #2;
    rst = 1'b0;
    i_if.valid = 1'b0;
    #1;
    chk("arst_valid", 160'(o_if.valid), 160'(0));
    chk("arst_ctrl", 160'(o_if.ctrl), 160'(0));
    chk("arst_pc", 160'(o_if.pc), 160'(0));
    chk("arst_stall_cnt", 160'(stall_cnt), 160'(0));
    chk("arst_ready", 160'(i_if.ready), 160'(1));
    #3 rst = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_ready", 160'(i_if.ready), 160'(1));
    step(1'b1, 41, 1'b1, 1'b0);
    chk("post_rst_valid", 160'(o_if.valid), 160'(1));
    chk("post_rst_pc", 160'(o_if.pc), 160'(32'h10A4));
    step(1'b0, 0, 1'b1, 1'b0);

    // Three operand channels, stale payload after flush
    i6.valid = 1'b1;
    i6.ctrl  = 9'h1A3;
    i6.pc    = 16'h0BEE;
    i6.ops   = {16'hC0DE, 16'h2222, 16'h1111};
    i6.imm   = 24'h00_0123;
    i6.regs  = 12'h321;
    o6.ready = 1'b0;
    @(posedge clk);
    #1;
    i6.valid = 1'b0;
    ops6 = o6.ops;
    chk("w6_valid", 160'(o6.valid), 160'(1));
    chk("w6_ctrl", 160'(o6.ctrl), 160'(9'h1A3));
    chk("w6_op2", 160'(ops6[47:32]), 160'(16'hC0DE));
    chk("w6_ops", 160'(ops6), 160'(48'hC0DE_2222_1111));
    chk("w6_pc", 160'(o6.pc), 160'(16'h0BEE));
    flush6 = 1'b1;
    @(posedge clk);
    #1;
    flush6 = 1'b0;
    ops6 = o6.ops;
    chk("w6_flush_valid", 160'(o6.valid), 160'(0));
    chk("w6_flush_ctrl", 160'(o6.ctrl), 160'(0));
    chk("w6_stale_pc", 160'(o6.pc), 160'(16'h0BEE));
    chk("w6_stale_ops", 160'(ops6), 160'(48'hC0DE_2222_1111));
    chk("w6_flush_ready", 160'(i6.ready), 160'(1));

    @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
